// File: rtl/axi_txn_limiter_pkg.sv
// Shared widths and types for the outstanding-transaction limiter.
// Default caps, counter typedefs and the counter-width helper.
package axi_txn_limiter_pkg;

  localparam int unsigned DEF_MAX_PER_ID = 4;
  localparam int unsigned DEF_MAX_TOTAL  = 8;

  function automatic int unsigned cnt_width(input int unsigned max);
    return $clog2(max + 1);
  endfunction

  // Counter types for the default caps.
  typedef logic [cnt_width(DEF_MAX_PER_ID)-1:0] cnt_t;
  typedef logic [cnt_width(DEF_MAX_TOTAL)-1:0]  total_t;

endpackage

// File: rtl/axi_bus_if.sv
// AXI4 bus bundle, one channel set, with master and slave views.
// Ports: none; parameters set address, data, ID and user widths.
interface AXI_BUS #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned USER_WIDTH = 8
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic [3:0]            aw_cache;
  logic [2:0]            aw_prot;
  logic [USER_WIDTH-1:0] aw_user;
  logic                  aw_valid;
  logic                  aw_ready;

  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_last;
  logic [USER_WIDTH-1:0] w_user;
  logic                  w_valid;
  logic                  w_ready;

  logic [ID_WIDTH-1:0]   b_id;
  logic [1:0]            b_resp;
  logic [USER_WIDTH-1:0] b_user;
  logic                  b_valid;
  logic                  b_ready;

  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic [3:0]            ar_cache;
  logic [2:0]            ar_prot;
  logic [USER_WIDTH-1:0] ar_user;
  logic                  ar_valid;
  logic                  ar_ready;

  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic [USER_WIDTH-1:0] r_user;
  logic                  r_valid;
  logic                  r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_cache, aw_prot, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_cache, ar_prot, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_cache, aw_prot, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_cache, ar_prot, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi_txn_counter.sv
// Per-ID and total outstanding counters for one direction.
// Ports: clk, rst, inc/dec strobes with IDs, query_id -> full, busy, underflow.
module axi_txn_counter
  import axi_txn_limiter_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MAX_PER_ID = DEF_MAX_PER_ID,
  parameter int unsigned MAX_TOTAL  = DEF_MAX_TOTAL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_valid,
  input  logic [ID_WIDTH-1:0] inc_id,
  input  logic                dec_valid,
  input  logic [ID_WIDTH-1:0] dec_id,
  input  logic [ID_WIDTH-1:0] query_id,
  output logic                full,
  output logic                busy,
  output logic                underflow
);
  localparam int unsigned NID = 2 ** ID_WIDTH;
  localparam int unsigned CW  = cnt_width(MAX_PER_ID);
  localparam int unsigned TW  = cnt_width(MAX_TOTAL);
  localparam logic [CW-1:0] CMAX = CW'(MAX_PER_ID);
  localparam logic [TW-1:0] TMAX = TW'(MAX_TOTAL);

  logic [CW-1:0] cnt_q [NID];
  logic [CW-1:0] cnt_d [NID];
  logic [TW-1:0] total_q;
  logic [TW-1:0] total_d;
  logic          total_zero;

  assign total_zero = (total_q == '0);
  assign underflow  = dec_valid &
                      ((cnt_q[dec_id] == '0) | total_zero);
  assign full = (cnt_q[query_id] == CMAX) |
                (total_q == TMAX);
  assign busy = ~total_zero;

  // A counter already at zero ignores the decrement
  // instead of wrapping; underflow reports it.
  always_comb begin
    for (int i = 0; i < NID; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_valid && inc_id == ID_WIDTH'(i))
        cnt_d[i] = cnt_d[i] + CW'(1);
      if (dec_valid && dec_id == ID_WIDTH'(i) &&
          cnt_q[i] != '0)
        cnt_d[i] = cnt_d[i] - CW'(1);
    end
    total_d = total_q;
    if (inc_valid)
      total_d = total_d + TW'(1);
    if (dec_valid && !total_zero)
      total_d = total_d - TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NID; i++)
        cnt_q[i] <= '0;
      total_q <= '0;
    end else begin
      for (int i = 0; i < NID; i++)
        cnt_q[i] <= cnt_d[i];
      total_q <= total_d;
    end
  end

endmodule

// File: rtl/axi_txn_limiter.sv
// Caps outstanding AXI writes/reads per ID and in total.
// Ports: clk_i, rst_i, in (slave), out (master), busy_o, err_o.
module axi_txn_limiter
  import axi_txn_limiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MAX_PER_ID = DEF_MAX_PER_ID,
  parameter int unsigned MAX_TOTAL  = DEF_MAX_TOTAL
) (
  input  logic   clk_i,
  input  logic   rst_i,
  AXI_BUS.Slave  in,
  AXI_BUS.Master out,
  output logic   busy_o,
  output logic   err_o
);
  if (ADDR_WIDTH < 1 || DATA_WIDTH < 8 || USER_WIDTH < 1 ||
      MAX_PER_ID < 1 || MAX_TOTAL < MAX_PER_ID) begin : g_bad
    $error("axi_txn_limiter: bad parameters");
  end

  logic stall_aw, stall_ar;
  logic aw_inc, ar_inc, b_dec, r_dec;
  logic wr_busy, rd_busy, wr_uf, rd_uf;
  logic err_q;

  // Stall only depends on registered counts, so a request
  // that is not stalled stays unstalled until it handshakes.
  assign out.aw_valid = in.aw_valid & ~stall_aw;
  assign in.aw_ready  = out.aw_ready & ~stall_aw;
  assign out.ar_valid = in.ar_valid & ~stall_ar;
  assign in.ar_ready  = out.ar_ready & ~stall_ar;

  assign aw_inc = in.aw_valid & ~stall_aw & out.aw_ready;
  assign ar_inc = in.ar_valid & ~stall_ar & out.ar_ready;
  assign b_dec  = out.b_valid & in.b_ready;
  assign r_dec  = out.r_valid & in.r_ready & out.r_last;

  assign out.aw_id    = in.aw_id;
  assign out.aw_addr  = in.aw_addr;
  assign out.aw_len   = in.aw_len;
  assign out.aw_size  = in.aw_size;
  assign out.aw_burst = in.aw_burst;
  assign out.aw_cache = in.aw_cache;
  assign out.aw_prot  = in.aw_prot;
  assign out.aw_user  = in.aw_user;

  assign out.w_data  = in.w_data;
  assign out.w_strb  = in.w_strb;
  assign out.w_last  = in.w_last;
  assign out.w_user  = in.w_user;
  assign out.w_valid = in.w_valid;
  assign in.w_ready  = out.w_ready;

  assign in.b_id     = out.b_id;
  assign in.b_resp   = out.b_resp;
  assign in.b_user   = out.b_user;
  assign in.b_valid  = out.b_valid;
  assign out.b_ready = in.b_ready;

  assign out.ar_id    = in.ar_id;
  assign out.ar_addr  = in.ar_addr;
  assign out.ar_len   = in.ar_len;
  assign out.ar_size  = in.ar_size;
  assign out.ar_burst = in.ar_burst;
  assign out.ar_cache = in.ar_cache;
  assign out.ar_prot  = in.ar_prot;
  assign out.ar_user  = in.ar_user;

  assign in.r_id     = out.r_id;
  assign in.r_data   = out.r_data;
  assign in.r_resp   = out.r_resp;
  assign in.r_last   = out.r_last;
  assign in.r_user   = out.r_user;
  assign in.r_valid  = out.r_valid;
  assign out.r_ready = in.r_ready;

  axi_txn_counter #(
    .ID_WIDTH   (ID_WIDTH),
    .MAX_PER_ID (MAX_PER_ID),
    .MAX_TOTAL  (MAX_TOTAL)
  ) u_wr (
    .clk       (clk_i),
    .rst       (rst_i),
    .inc_valid (aw_inc),
    .inc_id    (in.aw_id),
    .dec_valid (b_dec),
    .dec_id    (out.b_id),
    .query_id  (in.aw_id),
    .full      (stall_aw),
    .busy      (wr_busy),
    .underflow (wr_uf)
  );

  axi_txn_counter #(
    .ID_WIDTH   (ID_WIDTH),
    .MAX_PER_ID (MAX_PER_ID),
    .MAX_TOTAL  (MAX_TOTAL)
  ) u_rd (
    .clk       (clk_i),
    .rst       (rst_i),
    .inc_valid (ar_inc),
    .inc_id    (in.ar_id),
    .dec_valid (r_dec),
    .dec_id    (out.r_id),
    .query_id  (in.ar_id),
    .full      (stall_ar),
    .busy      (rd_busy),
    .underflow (rd_uf)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i)
      err_q <= 1'b0;
    else if (wr_uf | rd_uf)
      err_q <= 1'b1;
  end

  assign busy_o = wr_busy | rd_busy;
  assign err_o  = err_q;

endmodule

// File: tb/tb_axi_txn_limiter.sv
// Bench for axi_txn_limiter: directed cap/release cases,
// then randomized traffic against a counting reference model.
module tb_axi_txn_limiter;
  localparam int unsigned AW_W = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned UW   = 8;
  localparam int unsigned IW   = 4;
  localparam int          MPI  = 4;
  localparam int          MT   = 8;
  localparam int          NID  = 16;

  logic clk = 1'b0;
  logic rst;
  logic busy, err;

  always #5 clk = ~clk;

  AXI_BUS #(.ADDR_WIDTH(AW_W), .DATA_WIDTH(DW),
            .ID_WIDTH(IW), .USER_WIDTH(UW)) up ();
  AXI_BUS #(.ADDR_WIDTH(AW_W), .DATA_WIDTH(DW),
            .ID_WIDTH(IW), .USER_WIDTH(UW)) dn ();

  axi_txn_limiter #(
    .ADDR_WIDTH (AW_W),
    .DATA_WIDTH (DW),
    .USER_WIDTH (UW),
    .ID_WIDTH   (IW),
    .MAX_PER_ID (MPI),
    .MAX_TOTAL  (MT)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .in     (up),
    .out    (dn),
    .busy_o (busy),
    .err_o  (err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model: outstanding counts per ID and in total.
  int wr_cnt [NID];
  int rd_cnt [NID];
  int wr_tot, rd_tot;
  bit m_err;
  bit aw_hs, ar_hs, b_hs, r_hs, r_beat;

  function automatic bit capped(input int c, input int t);
    return (c >= MPI) || (t >= MT);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NID; i++) begin
      wr_cnt[i] = 0;
      rd_cnt[i] = 0;
    end
    wr_tot = 0;
    rd_tot = 0;
    m_err  = 1'b0;
  endtask

  // Called shortly after a rising edge with inputs driven;
  // checks outputs, advances the model, returns at edge+1.
  task automatic step();
    bit s_aw, s_ar;
    int bid, rid, awid, arid;
    #3;
    awid = int'(up.aw_id);
    arid = int'(up.ar_id);
    bid  = int'(dn.b_id);
    rid  = int'(dn.r_id);
    s_aw = capped(wr_cnt[awid], wr_tot);
    s_ar = capped(rd_cnt[arid], rd_tot);
    chk("aw_valid", 64'(dn.aw_valid),
        64'(up.aw_valid & !s_aw));
    chk("aw_ready", 64'(up.aw_ready),
        64'(dn.aw_ready & !s_aw));
    chk("ar_valid", 64'(dn.ar_valid),
        64'(up.ar_valid & !s_ar));
    chk("ar_ready", 64'(up.ar_ready),
        64'(dn.ar_ready & !s_ar));
    chk("aw_pass",
        64'({dn.aw_id, dn.aw_addr, dn.aw_len, dn.aw_user}),
        64'({up.aw_id, up.aw_addr, up.aw_len, up.aw_user}));
    chk("ar_pass",
        64'({dn.ar_id, dn.ar_addr, dn.ar_len, dn.ar_user}),
        64'({up.ar_id, up.ar_addr, up.ar_len, up.ar_user}));
    chk("w_pass",
        64'({dn.w_data, dn.w_strb, dn.w_last, dn.w_valid,
             up.w_ready}),
        64'({up.w_data, up.w_strb, up.w_last, up.w_valid,
             dn.w_ready}));
    chk("b_pass",
        64'({up.b_id, up.b_resp, up.b_valid, dn.b_ready}),
        64'({dn.b_id, dn.b_resp, dn.b_valid, up.b_ready}));
    chk("r_pass",
        64'({up.r_id, up.r_data, up.r_last, up.r_valid,
             dn.r_ready}),
        64'({dn.r_id, dn.r_data, dn.r_last, dn.r_valid,
             up.r_ready}));
    chk("busy", 64'(busy), 64'(wr_tot != 0 || rd_tot != 0));
    chk("err", 64'(err), 64'(m_err));
    aw_hs  = up.aw_valid && !s_aw && dn.aw_ready;
    ar_hs  = up.ar_valid && !s_ar && dn.ar_ready;
    b_hs   = dn.b_valid && up.b_ready;
    r_beat = dn.r_valid && up.r_ready;
    r_hs   = r_beat && dn.r_last;
    if (rst) begin
      clear_model();
    end else begin
      if (b_hs) begin
        if (wr_cnt[bid] == 0 || wr_tot == 0) m_err = 1'b1;
        if (wr_cnt[bid] > 0) wr_cnt[bid]--;
        if (wr_tot > 0) wr_tot--;
      end
      if (r_hs) begin
        if (rd_cnt[rid] == 0 || rd_tot == 0) m_err = 1'b1;
        if (rd_cnt[rid] > 0) rd_cnt[rid]--;
        if (rd_tot > 0) rd_tot--;
      end
      if (aw_hs) begin
        wr_cnt[awid]++;
        wr_tot++;
      end
      if (ar_hs) begin
        rd_cnt[arid]++;
        rd_tot++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    up.aw_valid = 1'b0; up.aw_id = '0; up.aw_addr = '0;
    up.aw_len = '0; up.aw_size = 3'd2; up.aw_burst = 2'd1;
    up.aw_cache = '0; up.aw_prot = '0; up.aw_user = '0;
    up.ar_valid = 1'b0; up.ar_id = '0; up.ar_addr = '0;
    up.ar_len = '0; up.ar_size = 3'd2; up.ar_burst = 2'd1;
    up.ar_cache = '0; up.ar_prot = '0; up.ar_user = '0;
    up.w_valid = 1'b0; up.w_data = '0; up.w_strb = '0;
    up.w_last = 1'b0; up.w_user = '0;
    up.b_ready = 1'b0; up.r_ready = 1'b0;
    dn.aw_ready = 1'b0; dn.ar_ready = 1'b0; dn.w_ready = 1'b0;
    dn.b_valid = 1'b0; dn.b_id = '0; dn.b_resp = '0;
    dn.b_user = '0;
    dn.r_valid = 1'b0; dn.r_id = '0; dn.r_data = '0;
    dn.r_resp = '0; dn.r_last = 1'b0; dn.r_user = '0;
  endtask

  // Random traffic: a slave that only answers accepted requests.
  typedef struct packed {
    logic [3:0] id;
    logic [7:0] len;
  } rd_t;

  int unsigned wq[$];
  rd_t         rq[$];
  int          r_idx, r_len;

  function automatic logic [3:0] pick_id();
    if ($urandom_range(0, 3) == 0)
      return 4'($urandom_range(0, 15));
    return 4'($urandom_range(0, 3));
  endfunction

  task automatic rand_cycle();
    int  k;
    rd_t e;
    if (rst) begin
      rst = 1'b0;
      wq.delete();
      rq.delete();
      idle_all();
      return;
    end
    if (aw_hs) begin
      wq.push_back(int'(up.aw_id));
      up.aw_valid = 1'b0;
    end
    if (ar_hs) begin
      rq.push_back('{id: up.ar_id, len: up.ar_len});
      up.ar_valid = 1'b0;
    end
    if (b_hs) dn.b_valid = 1'b0;
    if (r_beat) begin
      if (dn.r_last) begin
        dn.r_valid = 1'b0;
      end else begin
        r_idx++;
        dn.r_last = (r_idx == r_len);
        dn.r_data = $urandom;
      end
    end
    if (!up.aw_valid && $urandom_range(0, 1) == 1) begin
      up.aw_valid = 1'b1;
      up.aw_id    = pick_id();
      up.aw_addr  = $urandom;
      up.aw_len   = 8'($urandom_range(0, 7));
      up.aw_user  = 8'($urandom);
    end
    if (!up.ar_valid && $urandom_range(0, 1) == 1) begin
      up.ar_valid = 1'b1;
      up.ar_id    = pick_id();
      up.ar_addr  = $urandom;
      up.ar_len   = 8'($urandom_range(0, 3));
      up.ar_user  = 8'($urandom);
    end
    if (!dn.b_valid && wq.size() > 0 &&
        $urandom_range(0, 2) == 0) begin
      k = $urandom_range(0, wq.size() - 1);
      dn.b_id = 4'(wq[k]);
      wq.delete(k);
      dn.b_resp  = 2'($urandom);
      dn.b_valid = 1'b1;
    end
    if (!dn.r_valid && rq.size() > 0 &&
        $urandom_range(0, 1) == 1) begin
      k = $urandom_range(0, rq.size() - 1);
      e = rq[k];
      rq.delete(k);
      r_idx = 0;
      r_len = int'(e.len);
      dn.r_id    = e.id;
      dn.r_last  = (e.len == 8'd0);
      dn.r_data  = $urandom;
      dn.r_valid = 1'b1;
    end
    dn.aw_ready = 1'($urandom);
    dn.ar_ready = 1'($urandom);
    dn.w_ready  = 1'($urandom);
    up.b_ready  = 1'($urandom);
    up.r_ready  = 1'($urandom);
    up.w_valid  = 1'($urandom);
    up.w_data   = $urandom;
    up.w_strb   = 4'($urandom);
    up.w_last   = 1'($urandom);
    if ($urandom_range(0, 499) == 0) rst = 1'b1;
  endtask

  initial begin
    idle_all();
    clear_model();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    step();

    // Per-ID cap on id 2, then one-cycle release bubble
    up.aw_valid = 1'b1; up.aw_id = 4'd2; dn.aw_ready = 1'b1;
    up.b_ready = 1'b1; up.w_valid = 1'b1;
    up.w_data = 32'hcafe_f00d; up.w_strb = 4'hf;
    repeat (4) step();
    #1; chk("id_cap_held", 64'(dn.aw_valid), 64'd0);
    step();
    dn.b_valid = 1'b1; dn.b_id = 4'd2;
    #1; chk("rel_same_cyc", 64'(dn.aw_valid), 64'd0);
    step();
    dn.b_valid = 1'b0;
    #1; chk("rel_next_cyc", 64'(dn.aw_valid), 64'd1);
    step();
    up.aw_valid = 1'b0;
    dn.b_valid = 1'b1;
    repeat (4) step();
    dn.b_valid = 1'b0;
    #1; chk("drained", 64'(busy), 64'd0);
    step();

    // Total cap: ids 0..7 fill it, id 8 waits for a B
    up.aw_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      up.aw_id = 4'(i);
      step();
    end
    up.aw_id = 4'd8;
    #1; chk("tot_cap_held", 64'(dn.aw_valid), 64'd0);
    step();
    dn.b_valid = 1'b1; dn.b_id = 4'd5;
    step();
    dn.b_valid = 1'b0;
    #1; chk("tot_rel", 64'(dn.aw_valid), 64'd1);
    step();
    up.aw_valid = 1'b0;

    // Reset with writes outstanding
    rst = 1'b1;
    step();
    rst = 1'b0;
    up.aw_valid = 1'b1; up.aw_id = 4'd0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_aw", 64'(dn.aw_valid), 64'd1);
    step();
    up.aw_valid = 1'b0;
    dn.b_valid = 1'b1; dn.b_id = 4'd0;
    step();
    dn.b_valid = 1'b0;

    // Same-cycle AW and B on id 3 with id 1 full
    up.aw_valid = 1'b1; up.aw_id = 4'd1;
    repeat (4) step();
    up.aw_id = 4'd3;
    step();
    dn.b_valid = 1'b1; dn.b_id = 4'd3;
    #1; chk("simul_aw", 64'(dn.aw_valid), 64'd1);
    step();
    dn.b_valid = 1'b0; up.aw_valid = 1'b0;
    #1; chk("simul_busy", 64'(busy), 64'd1);
    step();

    // Read cap: only the last R beat frees a slot
    up.ar_valid = 1'b1; up.ar_id = 4'd0; up.ar_len = 8'd3;
    dn.ar_ready = 1'b1; up.r_ready = 1'b1;
    repeat (4) step();
    #1; chk("rd_cap_held", 64'(dn.ar_valid), 64'd0);
    step();
    dn.r_valid = 1'b1; dn.r_id = 4'd0; dn.r_last = 1'b0;
    repeat (3) step();
    dn.r_last = 1'b1;
    #1; chk("rd_nonlast", 64'(dn.ar_valid), 64'd0);
    step();
    dn.r_valid = 1'b0; dn.r_last = 1'b0;
    #1; chk("rd_rel", 64'(dn.ar_valid), 64'd1);
    step();
    up.ar_valid = 1'b0;

    // Underflow with nothing outstanding
    rst = 1'b1;
    step();
    rst = 1'b0;
    dn.b_valid = 1'b1; dn.b_id = 4'd7; up.b_ready = 1'b1;
    #1;
    chk("uf_fwd", 64'(up.b_valid), 64'd1);
    chk("uf_err_now", 64'(err), 64'd0);
    step();
    dn.b_valid = 1'b0;
    #1;
    chk("uf_err", 64'(err), 64'd1);
    chk("uf_busy", 64'(busy), 64'd0);
    repeat (3) step();
    #1; chk("uf_err_held", 64'(err), 64'd1);
    step();

    // Randomized traffic
    rst = 1'b1;
    step();
    repeat (4000) begin
      rand_cycle();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
